// File: rtl/alu_defs.sv
// Shared definitions for the ALU control path: opcodes, ALU mux select codes,
// control-FSM state encoding and the decoded-control bundle.
package alu_defs;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // Select codes understood by the downstream ALU result mux.
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_control_fsm_if.sv
// Instruction handshake plus ALU/register-file control bundle for alu_control_fsm.
// Handshake: a transfer happens on the rising CLK edge where INSTR_VALID and
// INSTR_READY are both 1; the source holds INSTRUCTION stable until then.
interface alu_control_fsm_if #(
  parameter int CNT_W = 16
);
  import alu_defs::*;

  logic [31:0]      INSTRUCTION;
  logic             INSTR_VALID;
  logic             INSTR_READY;
  logic [2:0]       ALUOP;
  logic             IMM_SEL;
  logic             NEG_SEL;
  logic [7:0]       IMMEDIATE;
  logic [2:0]       READREG1;
  logic [2:0]       READREG2;
  logic [2:0]       WRITEREG;
  logic             WRITEENABLE;
  logic             ILLEGAL;
  logic             DONE;
  logic [CNT_W-1:0] INSTR_COUNT;
  state_t           fsm_state;

  modport master (
    output INSTRUCTION, INSTR_VALID,
    input  INSTR_READY, ALUOP, IMM_SEL, NEG_SEL, IMMEDIATE, READREG1, READREG2,
           WRITEREG, WRITEENABLE, ILLEGAL, DONE, INSTR_COUNT, fsm_state
  );

  modport slave (
    input  INSTRUCTION, INSTR_VALID,
    output INSTR_READY, ALUOP, IMM_SEL, NEG_SEL, IMMEDIATE, READREG1, READREG2,
           WRITEREG, WRITEENABLE, ILLEGAL, DONE, INSTR_COUNT, fsm_state
  );

endinterface

// File: rtl/op_decode.sv
// Combinational opcode decoder shared by the sequenced and any future pipelined
// control path. Unknown opcodes flag illegal and fall back to a safe forward select.
module op_decode
  import alu_defs::*;
(
  input  logic [7:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.aluop = ALU_FWD;
    case (opcode)
      OP_LOADI: ctrl.imm_sel = 1'b1;
      OP_MOV:   ctrl.aluop   = ALU_FWD;
      OP_ADD:   ctrl.aluop   = ALU_ADD;
      OP_SUB: begin
        ctrl.aluop   = ALU_ADD;
        ctrl.neg_sel = 1'b1;
      end
      OP_AND:   ctrl.aluop   = ALU_AND;
      OP_OR:    ctrl.aluop   = ALU_OR;
      default:  ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_fsm.sv
// Sequenced ALU control stage: accepts one instruction, drives registered ALU
// controls through EXEC and WB, strobes the register-file write and counts retirements.
module alu_control_fsm
  import alu_defs::*;
#(
  parameter int CNT_W = 16
) (
  input logic               CLK,
  input logic               RESET,
  alu_control_fsm_if.slave  bus
);

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [2:0]       aluop_q, aluop_d;
  logic             imm_sel_q, imm_sel_d;
  logic             neg_sel_q, neg_sel_d;
  logic             we_q, we_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [7:0] dec_opcode;
  ctrl_t      dec;

  // In IDLE the controls must be ready in the first EXEC cycle, so decode the
  // incoming word; afterwards decode the latched one.
  assign dec_opcode = (state_q == S_IDLE) ? bus.INSTRUCTION[31:24] : instr_q[31:24];

  op_decode u_op_decode (
    .opcode (dec_opcode),
    .ctrl   (dec)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    aluop_d   = ALU_FWD;
    imm_sel_d = 1'b0;
    neg_sel_d = 1'b0;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    done_d    = 1'b0;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.INSTR_VALID) begin
          state_d   = S_EXEC;
          instr_d   = bus.INSTRUCTION;
          aluop_d   = dec.aluop;
          imm_sel_d = dec.imm_sel;
          neg_sel_d = dec.neg_sel;
        end
      end
      S_EXEC: begin
        state_d   = S_WB;
        aluop_d   = dec.aluop;
        imm_sel_d = dec.imm_sel;
        neg_sel_d = dec.neg_sel;
        done_d    = 1'b1;
        if (dec.illegal) begin
          illegal_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      aluop_q   <= ALU_FWD;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      aluop_q   <= aluop_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Upper bits of the register-address bytes carry no meaning for a 3-bit file.
  logic unused_fields;
  assign unused_fields = ^{instr_q[23:19], instr_q[15:11]};

  assign bus.INSTR_READY = (state_q == S_IDLE);
  assign bus.ALUOP       = aluop_q;
  assign bus.IMM_SEL     = imm_sel_q;
  assign bus.NEG_SEL     = neg_sel_q;
  assign bus.IMMEDIATE   = instr_q[7:0];
  assign bus.READREG1    = instr_q[10:8];
  assign bus.READREG2    = instr_q[2:0];
  assign bus.WRITEREG    = instr_q[18:16];
  assign bus.WRITEENABLE = we_q;
  assign bus.ILLEGAL     = illegal_q;
  assign bus.DONE        = done_q;
  assign bus.INSTR_COUNT = count_q;
  assign bus.fsm_state   = state_q;

endmodule
